// File: rtl/servo_sequencer.sv
// servo_sequencer: N-channel servo controller driven by opcode/channel/position
// instructions over a valid/ready handshake.  A shared frame counter produces
// one PWM output per channel.  Each enabled channel slews toward its target by
// at most SLEW_STEP positions per frame and pulses done_mask on arrival.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr_valid/ready     instruction handshake (one instruction per 2 cycles)
//   instr_op              00 STOP, 01 MOVE, 10 EXTEND, 11 RETRACT
//   instr_ch              target channel
//   instr_pos             MOVE target position
//   servo_out[NUM_CH]     PWM outputs
//   ch_busy[NUM_CH]       channel enabled with a command pending
//   done_mask[NUM_CH]     one-cycle pulse per channel on command completion
//   err                   one-cycle pulse when an instruction is rejected
module servo_sequencer #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned POS_W         = 8,
  parameter int unsigned PERIOD_CYCLES = 1500000,
  parameter int unsigned MIN_PULSE     = 50000,
  parameter int unsigned STEP_CYCLES   = 196,
  parameter int unsigned SLEW_STEP     = 8,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CNT_W        = $clog2(PERIOD_CYCLES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [CH_W-1:0]   instr_ch,
  input  logic [POS_W-1:0]  instr_pos,
  output logic [NUM_CH-1:0] servo_out,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] done_mask,
  output logic              err
);

  // The longest pulse must fit inside one frame.
  if (MIN_PULSE + ((2 ** POS_W) - 1) * STEP_CYCLES >= PERIOD_CYCLES) begin : g_bad_timing
    $error("servo_sequencer: maximum pulse does not fit in PERIOD_CYCLES");
  end

  typedef enum logic {ST_IDLE, ST_DISPATCH} state_e;
  typedef enum logic [1:0] {OP_STOP = 2'b00, OP_MOVE = 2'b01,
                            OP_EXTEND = 2'b10, OP_RETRACT = 2'b11} op_e;

  localparam logic [POS_W-1:0] POS_MID = POS_W'(1) << (POS_W - 1);
  localparam logic [POS_W-1:0] POS_MAX = '1;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   count_q, count_d;
  op_e                op_q, op_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [POS_W-1:0]   pos_q, pos_d;

  logic [POS_W-1:0]   cur_q [NUM_CH];
  logic [POS_W-1:0]   cur_d [NUM_CH];
  logic [POS_W-1:0]   tgt_q [NUM_CH];
  logic [POS_W-1:0]   tgt_d [NUM_CH];
  logic [CNT_W-1:0]   pulse_len_q [NUM_CH];
  logic [CNT_W-1:0]   pulse_len_d [NUM_CH];
  logic [NUM_CH-1:0]  enable_q, enable_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;

  logic [NUM_CH-1:0]  servo_q, servo_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic               err_q, err_d;

  logic               boundary;
  logic               dispatch;
  logic               bad_ch;
  logic [POS_W-1:0]   cur_nx;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    op_d        = op_q;
    ch_d        = ch_q;
    pos_d       = pos_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    pulse_len_d = pulse_len_q;
    enable_d    = enable_q;
    pending_d   = pending_q;
    servo_d     = '0;
    busy_d      = '0;
    done_d      = '0;
    err_d       = 1'b0;
    cur_nx      = '0;

    count_d  = (count_q == CNT_W'(PERIOD_CYCLES - 1)) ? '0 : count_q + CNT_W'(1);
    boundary = (count_q == '0);
    dispatch = (state_q == ST_DISPATCH);
    bad_ch   = (32'(ch_q) >= NUM_CH);

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (instr_valid && ready_q) begin
          op_d    = op_e'(instr_op);
          ch_d    = instr_ch;
          pos_d   = instr_pos;
          state_d = ST_DISPATCH;
          ready_d = 1'b0;
        end
      end
      ST_DISPATCH: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase

    err_d = dispatch && bad_ch;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // Slew one frame's worth toward the target without overshooting.
      cur_nx = cur_q[i];
      if (cur_q[i] < tgt_q[i]) begin
        if (SLEW_STEP == 0 || 32'(tgt_q[i] - cur_q[i]) <= SLEW_STEP) cur_nx = tgt_q[i];
        else cur_nx = cur_q[i] + POS_W'(SLEW_STEP);
      end else if (cur_q[i] > tgt_q[i]) begin
        if (SLEW_STEP == 0 || 32'(cur_q[i] - tgt_q[i]) <= SLEW_STEP) cur_nx = tgt_q[i];
        else cur_nx = cur_q[i] - POS_W'(SLEW_STEP);
      end

      if (boundary && enable_q[i]) begin
        cur_d[i]       = cur_nx;
        pulse_len_d[i] = CNT_W'(32'(MIN_PULSE) + 32'(cur_nx) * 32'(STEP_CYCLES));
        if (pending_q[i] && cur_nx == tgt_q[i]) begin
          done_d[i]    = 1'b1;
          pending_d[i] = 1'b0;
        end
      end

      // A dispatch landing on a boundary overrides that boundary's completion:
      // the superseded command never reports done.
      if (dispatch && !bad_ch && 32'(ch_q) == i) begin
        done_d[i] = 1'b0;
        case (op_q)
          OP_STOP: begin
            enable_d[i]    = 1'b0;
            pending_d[i]   = 1'b0;
            pulse_len_d[i] = '0;
          end
          OP_MOVE: begin
            tgt_d[i]     = pos_q;
            enable_d[i]  = 1'b1;
            pending_d[i] = 1'b1;
          end
          OP_EXTEND: begin
            tgt_d[i]     = POS_MAX;
            enable_d[i]  = 1'b1;
            pending_d[i] = 1'b1;
          end
          default: begin
            tgt_d[i]     = '0;
            enable_d[i]  = 1'b1;
            pending_d[i] = 1'b1;
          end
        endcase
      end

      // Compare against the next-state enable and pulse length so a STOP cuts
      // the pulse the cycle after DISPATCH and a fresh frame's pulse is full
      // length.  pulse_len stays 0 while disabled, so a channel enabled
      // mid-frame waits for the next boundary.
      servo_d[i] = enable_d[i] && (count_q < pulse_len_d[i]);
      busy_d[i]  = enable_d[i] && pending_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      count_q   <= '0;
      op_q      <= OP_STOP;
      ch_q      <= '0;
      pos_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cur_q[i]       <= POS_MID;
        tgt_q[i]       <= POS_MID;
        pulse_len_q[i] <= '0;
      end
      enable_q  <= '0;
      pending_q <= '0;
      servo_q   <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      count_q     <= count_d;
      op_q        <= op_d;
      ch_q        <= ch_d;
      pos_q       <= pos_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      pulse_len_q <= pulse_len_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      servo_q     <= servo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign instr_ready = ready_q;
  assign servo_out   = servo_q;
  assign ch_busy     = busy_q;
  assign done_mask   = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_servo_sequencer.sv
// Testbench for servo_sequencer: directed scenarios followed by random
// instructions, all checked cycle by cycle against a behavioural model, plus
// pulse-width / done-count checks against hand-derived constants.
// Three channels are used so that channel index 3 is out of range with the
// 2-bit channel field.
module tb_servo_sequencer;

  localparam int NCH  = 3;
  localparam int PW   = 4;
  localparam int PER  = 100;
  localparam int MINP = 10;
  localparam int STP  = 1;
  localparam int SLEW = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           instr_valid;
  logic           instr_ready;
  logic [1:0]     instr_op;
  logic [1:0]     instr_ch;
  logic [PW-1:0]  instr_pos;
  logic [NCH-1:0] servo_out;
  logic [NCH-1:0] ch_busy;
  logic [NCH-1:0] done_mask;
  logic           err;

  servo_sequencer #(
    .NUM_CH(NCH), .POS_W(PW), .PERIOD_CYCLES(PER),
    .MIN_PULSE(MINP), .STEP_CYCLES(STP), .SLEW_STEP(SLEW)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_ch(instr_ch), .instr_pos(instr_pos),
    .servo_out(servo_out), .ch_busy(ch_busy), .done_mask(done_mask), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cur [NCH];
  int m_tgt [NCH];
  int m_plen[NCH];
  bit m_en  [NCH];
  bit m_pend[NCH];
  bit m_act [NCH];   // channel was enabled at the start of the current frame
  int m_count;
  bit m_disp;
  int m_op, m_ch, m_pos;
  int m_d;
  bit m_bnd;
  bit             e_ready, e_err;
  logic [NCH-1:0] e_servo, e_busy, e_done;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cur[c] = 1 << (PW - 1); m_tgt[c] = 1 << (PW - 1);
      m_plen[c] = 0; m_en[c] = 0; m_pend[c] = 0; m_act[c] = 0;
    end
    m_count = 0; m_disp = 0; m_op = 0; m_ch = 0; m_pos = 0;
    e_ready = 0; e_err = 0; e_servo = '0; e_busy = '0; e_done = '0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    m_bnd  = (m_count == 0);
    e_done = '0;
    e_err  = 0;
    if (m_bnd) begin
      for (int c = 0; c < NCH; c++) begin
        if (m_en[c]) begin
          m_d = m_tgt[c] - m_cur[c];
          if (SLEW != 0 && m_d > SLEW)  m_d = SLEW;
          if (SLEW != 0 && m_d < -SLEW) m_d = -SLEW;
          m_cur[c] += m_d;
          m_plen[c] = MINP + m_cur[c] * STP;
          m_act[c]  = 1;
          if (m_pend[c] && m_cur[c] == m_tgt[c]) begin
            e_done[c] = 1'b1;
            m_pend[c] = 0;
          end
        end else begin
          m_act[c] = 0;
        end
      end
    end
    if (m_disp) begin
      if (m_ch >= NCH) begin
        e_err = 1;
      end else begin
        e_done[m_ch] = 1'b0;
        case (m_op)
          0: begin m_en[m_ch] = 0; m_pend[m_ch] = 0; m_act[m_ch] = 0; end
          1: begin m_tgt[m_ch] = m_pos; m_en[m_ch] = 1; m_pend[m_ch] = 1; end
          2: begin m_tgt[m_ch] = PMAX;  m_en[m_ch] = 1; m_pend[m_ch] = 1; end
          default: begin m_tgt[m_ch] = 0; m_en[m_ch] = 1; m_pend[m_ch] = 1; end
        endcase
      end
      m_disp  = 0;
      e_ready = 1;
    end else if (e_ready && instr_valid) begin
      m_op = int'(instr_op); m_ch = int'(instr_ch); m_pos = int'(instr_pos);
      m_disp  = 1;
      e_ready = 0;
    end else begin
      e_ready = 1;
    end
    for (int c = 0; c < NCH; c++) begin
      e_servo[c] = m_en[c] && m_act[c] && (m_count < m_plen[c]);
      e_busy[c]  = m_en[c] && m_pend[c];
    end
    m_count = (m_count + 1) % PER;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  bit chk_en = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("ready", 32'(instr_ready), 32'(e_ready));
      check("servo", 32'(servo_out),   32'(e_servo));
      check("busy",  32'(ch_busy),     32'(e_busy));
      check("done",  32'(done_mask),   32'(e_done));
      check("err",   32'(err),         32'(e_err));
    end
  end

  // ---------------- observation monitors ----------------
  int run[NCH];
  int last_len[NCH];
  int done_cnt[NCH];
  int err_cnt = 0;
  int hi_cnt  = 0;
  int pq0[$];
  int pq1[$];
  logic [NCH-1:0] done_hist[$];

  initial begin
    for (int c = 0; c < NCH; c++) begin run[c] = 0; last_len[c] = 0; done_cnt[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (servo_out[c] === 1'b1) begin
          run[c]++;
          hi_cnt++;
        end else if (run[c] > 0) begin
          last_len[c] = run[c];
          if (c == 0) pq0.push_back(run[c]);
          if (c == 1) pq1.push_back(run[c]);
          run[c] = 0;
        end
        if (done_mask[c] === 1'b1) done_cnt[c]++;
      end
      if (err === 1'b1) err_cnt++;
      if (done_mask !== '0 && !$isunknown(done_mask)) done_hist.push_back(done_mask);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [PW-1:0] pos);
    int n = 0;
    instr_valid = 1'b1; instr_op = op; instr_ch = ch; instr_pos = pos;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", 32'(instr_ready === 1'b1), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic align(input int c);
    for (int k = 0; k < 2 * PER && m_count != c; k++) @(negedge clk);
    check("align", 32'(m_count == c), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int d0, e0;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_op = 2'b00; instr_ch = 2'b00; instr_pos = '0;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_servo", 32'(servo_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(instr_ready), 32'd1);

    // Idle: no pulses for two full frames.
    idle(200);
    check("idle_no_pulse", 32'(hi_cnt), 32'd0);

    // MOVE ch0 8 -> 15: pulses 21, 24, 25.
    pq0.delete();
    send(2'b01, 2'd0, 4'd15);
    idle(400);
    check("mv0_p1", 32'(pq0.size() > 0 ? pq0[0] : 0), 32'd21);
    check("mv0_p2", 32'(pq0.size() > 1 ? pq0[1] : 0), 32'd24);
    check("mv0_p3", 32'(pq0.size() > 2 ? pq0[2] : 0), 32'd25);
    check("mv0_done_cnt", 32'(done_cnt[0]), 32'd1);
    check("mv0_busy", 32'(ch_busy), 32'd0);

    // ch0 15->9 and ch1 8->14, both two frames: simultaneous completion.
    align(10);
    done_hist.delete();
    send(2'b01, 2'd0, 4'd9);
    send(2'b01, 2'd1, 4'd14);
    idle(300);
    check("both_done_n", 32'(done_hist.size()), 32'd1);
    check("both_done_mask", 32'(done_hist.size() > 0 ? done_hist[0] : '0), 32'b011);

    // Retarget ch0 mid-move: exactly one done.
    d0 = done_cnt[0];
    send(2'b01, 2'd0, 4'd0);
    idle(150);
    send(2'b01, 2'd0, 4'd8);
    idle(400);
    check("retarget_done", 32'(done_cnt[0] - d0), 32'd1);
    check("retarget_len", 32'(last_len[0]), 32'd18);

    // STOP mid-pulse: output drops the cycle after DISPATCH, no done.
    d0 = done_cnt[0];
    align(2);
    send(2'b00, 2'd0, 4'd0);
    @(negedge clk);
    check("stop_cut", 32'(servo_out[0]), 32'd0);
    idle(200);
    check("stop_no_done", 32'(done_cnt[0] - d0), 32'd0);
    check("stop_busy", 32'(ch_busy[0]), 32'd0);

    // Out-of-range channel.
    e0 = err_cnt;
    send(2'b01, 2'd3, 4'd5);
    idle(5);
    check("err_pulse", 32'(err_cnt - e0), 32'd1);
    check("err_no_busy", 32'(ch_busy), 32'd0);

    // RETRACT ch1, EXTEND ch2.
    send(2'b11, 2'd1, 4'd0);
    send(2'b10, 2'd2, 4'd0);
    idle(700);
    check("retract_len", 32'(last_len[1]), 32'd10);
    check("extend_len", 32'(last_len[2]), 32'd25);

    // Reset mid-move, then a fresh MOVE behaves as from power-up.
    send(2'b01, 2'd1, 4'd15);
    idle(150);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_servo", 32'(servo_out), 32'd0);
    check("midrst_busy", 32'(ch_busy), 32'd0);
    check("midrst_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    pq1.delete();
    send(2'b01, 2'd1, 4'd15);
    idle(400);
    check("fresh_p1", 32'(pq1.size() > 0 ? pq1[0] : 0), 32'd21);
    check("fresh_p2", 32'(pq1.size() > 1 ? pq1[1] : 0), 32'd24);
    check("fresh_p3", 32'(pq1.size() > 2 ? pq1[2] : 0), 32'd25);

    // Random traffic against the model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        idle(int'($urandom_range(1, 3)));
        reset = 1'b0;
      end else begin
        send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), PW'($urandom_range(0, PMAX)));
      end
      idle(int'($urandom_range(0, 250)));
    end
    idle(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
